// File: rtl/branch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the branch comparator sequencing controller:
//   - state_e      : controller FSM states
//   - BR_*         : one-hot branch type encodings {eq, ge, le, carry}
//   - STAT_W       : width of the optional statistics counters
//   - is_onehot4() : legality check for a decoded branch type
// -----------------------------------------------------------------------------
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        RESOLVE   = 2'd2,
        FLUSH     = 2'd3
    } state_e;

    localparam logic [3:0] BR_EQ    = 4'b1000;
    localparam logic [3:0] BR_GE    = 4'b0100;
    localparam logic [3:0] BR_LE    = 4'b0010;
    localparam logic [3:0] BR_CARRY = 4'b0001;

    localparam int STAT_W = 16;

    // True when exactly one bit is set; rejects 0000 and any multi-hot code.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_ctrl_if
// Decode-to-controller branch handshake.
//   br_valid_pi   : decode presents a branch this cycle
//   br_type_pi    : one-hot {eq, ge, le, carry}
//   br_target_pi  : branch target address (PC_W bits)
//   br_ready_po   : controller can accept a branch
// Modports: master = ID-stage decode, slave = branch_ctrl.
// -----------------------------------------------------------------------------
interface branch_ctrl_if #(
    parameter int PC_W = 16
);
    logic            br_valid_pi;
    logic [3:0]      br_type_pi;
    logic [PC_W-1:0] br_target_pi;
    logic            br_ready_po;

    modport master (
        output br_valid_pi,
        output br_type_pi,
        output br_target_pi,
        input  br_ready_po
    );

    modport slave (
        input  br_valid_pi,
        input  br_type_pi,
        input  br_target_pi,
        output br_ready_po
    );
endinterface

// File: rtl/branch_ctrl_stats.sv
// -----------------------------------------------------------------------------
// branch_ctrl_stats
// Saturating event counters for the branch controller (built only when
// BRANCH_STATS_EN is defined in the top level).
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   resolve_i           : controller is in a RESOLVE cycle
//   taken_i             : RESOLVE cycle whose comparator result is taken
//   stall_i             : stall output is high this cycle
//   stat_resolved_o     : count of RESOLVE cycles
//   stat_taken_o        : count of taken branches
//   stat_stall_o        : count of stall cycles
// All counters stick at all-ones rather than wrapping.
// -----------------------------------------------------------------------------
module branch_ctrl_stats
    import branch_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              resolve_i,
    input  logic              taken_i,
    input  logic              stall_i,
    output logic [STAT_W-1:0] stat_resolved_o,
    output logic [STAT_W-1:0] stat_taken_o,
    output logic [STAT_W-1:0] stat_stall_o
);
    logic [STAT_W-1:0] resolved_q, taken_q, stall_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                   input logic               en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            resolved_q <= '0;
            taken_q    <= '0;
            stall_q    <= '0;
        end else begin
            resolved_q <= sat_inc(resolved_q, resolve_i);
            taken_q    <= sat_inc(taken_q, taken_i);
            stall_q    <= sat_inc(stall_q, stall_i);
        end
    end

    assign stat_resolved_o = resolved_q;
    assign stat_taken_o    = taken_q;
    assign stat_stall_o    = stall_q;
endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Sequencing controller for the 16-bit MIPS branch comparator. Accepts a
// decoded branch, waits for final operands, drives the one-hot comparator
// select, samples the taken result and, when taken, issues a one-cycle PC
// redirect followed by an IF/ID flush lasting FLUSH_CYCLES cycles.
//
// Parameters:
//   PC_W          : branch target / redirect PC width
//   FLUSH_CYCLES  : flush length after a taken branch (1..3)
// Ports:
//   clk_pi, reset_n_pi      : clock, asynchronous active-low reset
//   br_if (slave)           : decode handshake (valid/type/target/ready)
//   opnds_ready_pi          : register and carry operands are final
//   cmp_taken_pi            : comparator result, sampled at end of RESOLVE
//   br_{eq,ge,le,carry}_po  : comparator select lines (one-hot or zero)
//   stall_po, flush_po      : front-end freeze / IF/ID squash
//   redirect_valid_po       : one-cycle PC load strobe
//   redirect_pc_po          : redirect target, holds between pulses
// Optional (macro BRANCH_STATS_EN):
//   stat_resolved_po, stat_taken_po, stat_stall_po : saturating counters
// Every output is decoded from registered state only.
// -----------------------------------------------------------------------------
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk_pi,
    input  logic              reset_n_pi,
    branch_ctrl_if.slave      br_if,
    input  logic              opnds_ready_pi,
    input  logic              cmp_taken_pi,
    output logic              br_eq_po,
    output logic              br_ge_po,
    output logic              br_le_po,
    output logic              br_carry_po,
    output logic              stall_po,
    output logic              flush_po,
    output logic              redirect_valid_po,
    output logic [PC_W-1:0]   redirect_pc_po
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_resolved_po,
    output logic [STAT_W-1:0] stat_taken_po,
    output logic [STAT_W-1:0] stat_stall_po
`endif
);
    state_e          state_q, state_d;
    logic [3:0]      type_q, type_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [1:0]      flush_cnt_q, flush_cnt_d;
    logic            redir_valid_q, redir_valid_d;
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;
    logic            sel_active;

    // NOTE: every always_comb target gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        target_d      = target_q;
        flush_cnt_d   = flush_cnt_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;

        unique case (state_q)
            IDLE: begin
                // Illegal (zero or multi-hot) types are dropped silently.
                if (br_if.br_valid_pi && is_onehot4(br_if.br_type_pi)) begin
                    type_d   = br_if.br_type_pi;
                    target_d = br_if.br_target_pi;
                    state_d  = opnds_ready_pi ? RESOLVE : WAIT_OPND;
                end
            end
            WAIT_OPND: begin
                if (opnds_ready_pi) state_d = RESOLVE;
            end
            RESOLVE: begin
                if (cmp_taken_pi) begin
                    state_d       = FLUSH;
                    flush_cnt_d   = 2'(FLUSH_CYCLES);
                    // Registered so the pulse lands in the first FLUSH cycle.
                    redir_valid_d = 1'b1;
                    redir_pc_d    = target_q;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                // New branches from decode are squashed here, so br_valid_pi
                // is deliberately not looked at.
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_q == 2'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state_q       <= IDLE;
            type_q        <= '0;
            target_q      <= '0;
            flush_cnt_q   <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            target_q      <= target_d;
            flush_cnt_q   <= flush_cnt_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    // Selects follow the latched type only while the comparator is in use;
    // type_q is one-hot by construction, so the outputs never go multi-hot.
    assign sel_active = (state_q == WAIT_OPND) || (state_q == RESOLVE);

    assign br_eq_po          = sel_active & type_q[3];
    assign br_ge_po          = sel_active & type_q[2];
    assign br_le_po          = sel_active & type_q[1];
    assign br_carry_po       = sel_active & type_q[0];
    assign stall_po          = sel_active;
    assign flush_po          = (state_q == FLUSH);
    assign br_if.br_ready_po = (state_q == IDLE);
    assign redirect_valid_po = redir_valid_q;
    assign redirect_pc_po    = redir_pc_q;

`ifdef BRANCH_STATS_EN
    branch_ctrl_stats u_stats (
        .clk_i           (clk_pi),
        .rst_n_i         (reset_n_pi),
        .resolve_i       (state_q == RESOLVE),
        .taken_i         ((state_q == RESOLVE) && cmp_taken_pi),
        .stall_i         (sel_active),
        .stat_resolved_o (stat_resolved_po),
        .stat_taken_o    (stat_taken_po),
        .stat_stall_o    (stat_stall_po)
    );
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
// Self-checking bench for branch_ctrl with FLUSH_CYCLES = 2. Each branch is
// described as a transaction (type, target, operand wait, taken) and the
// expected per-cycle outputs are derived from the transaction's timeline:
// accept -> wait cycles -> resolve -> flush cycles -> idle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_ctrl;
    localparam int PC_W = 16;
    localparam int FC   = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic opnds_ready, cmp_taken;
    logic br_eq, br_ge, br_le, br_carry;
    logic stall, flush, redir_valid;
    logic [PC_W-1:0] redir_pc;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_resolved, stat_taken, stat_stall;
`endif

    branch_ctrl_if #(.PC_W(PC_W)) bif ();

    branch_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
        .clk_pi            (clk),
        .reset_n_pi        (reset_n),
        .br_if             (bif),
        .opnds_ready_pi    (opnds_ready),
        .cmp_taken_pi      (cmp_taken),
        .br_eq_po          (br_eq),
        .br_ge_po          (br_ge),
        .br_le_po          (br_le),
        .br_carry_po       (br_carry),
        .stall_po          (stall),
        .flush_po          (flush),
        .redirect_valid_po (redir_valid),
        .redirect_pc_po    (redir_pc)
`ifdef BRANCH_STATS_EN
        ,
        .stat_resolved_po  (stat_resolved),
        .stat_taken_po     (stat_taken),
        .stat_stall_po     (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [PC_W-1:0] last_pc;
    int exp_resolved, exp_taken, exp_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] t, input logic [PC_W-1:0] tgt,
                         input logic opr, input logic tk);
        bif.br_valid_pi  = v;
        bif.br_type_pi   = t;
        bif.br_target_pi = tgt;
        opnds_ready      = opr;
        cmp_taken        = tk;
    endtask

    task automatic expect_cycle(input string ph, input logic rdy, input logic stl,
                                input logic fl, input logic rv, input logic [3:0] sel);
        check({ph, ".ready"},  32'(bif.br_ready_po), 32'(rdy));
        check({ph, ".stall"},  32'(stall), 32'(stl));
        check({ph, ".flush"},  32'(flush), 32'(fl));
        check({ph, ".redir_v"}, 32'(redir_valid), 32'(rv));
        check({ph, ".redir_pc"}, 32'(redir_pc), 32'(last_pc));
        check({ph, ".sel"}, 32'({br_eq, br_ge, br_le, br_carry}), 32'(sel));
        if (stl) exp_stall++;
    endtask

    task automatic check_stats();
`ifdef BRANCH_STATS_EN
        check("stat_resolved", 32'(stat_resolved), 32'(exp_resolved));
        check("stat_taken",    32'(stat_taken),    32'(exp_taken));
        check("stat_stall",    32'(stat_stall),    32'(exp_stall));
`endif
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        expect_cycle("idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One branch transaction; the next call's first cycle checks the return
    // to IDLE.
    task automatic branch(input logic [3:0] typ, input logic [PC_W-1:0] tgt,
                          input int wait_n, input logic taken);
        logic legal;
        legal = ($countones(typ) == 1);
        @(negedge clk);
        expect_cycle("accept", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        drive(1'b1, typ, tgt, legal ? (wait_n == 0) : 1'($urandom), 1'($urandom));
        if (!legal) return;
        for (int k = 1; k <= wait_n; k++) begin
            @(negedge clk);
            expect_cycle("wait", 1'b0, 1'b1, 1'b0, 1'b0, typ);
            drive(1'($urandom), 4'($urandom), 16'($urandom), (k == wait_n), 1'($urandom));
        end
        @(negedge clk);
        expect_cycle("resolve", 1'b0, 1'b1, 1'b0, 1'b0, typ);
        exp_resolved++;
        if (taken) exp_taken++;
        drive(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), taken);
        if (taken) begin
            last_pc = tgt;
            for (int f = 0; f < FC; f++) begin
                @(negedge clk);
                expect_cycle("flush", 1'b0, 1'b0, 1'b1, (f == 0), 4'b0000);
                // A branch from decode during flush must be ignored.
                drive(1'b1, 4'b1000 >> $urandom_range(0, 3), 16'($urandom),
                      1'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        logic [3:0] typ;
        last_pc      = '0;
        exp_resolved = 0;
        exp_taken    = 0;
        exp_stall    = 0;
        reset_n      = 1'b0;
        drive(1'b0, 4'b0000, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        expect_cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        check_stats();
        reset_n = 1'b1;

        // Taken beq, not-taken bge, taken ble with a 2-cycle operand wait.
        branch(4'b1000, 16'h0040, 0, 1'b1);
        branch(4'b0100, 16'h1234, 0, 1'b0);
        branch(4'b0010, 16'h0abc, 2, 1'b1);
        idle_cycle();
`ifdef BRANCH_STATS_EN
        check("stat_resolved_3", 32'(stat_resolved), 32'd3);
        check("stat_taken_2",    32'(stat_taken),    32'd2);
        check("stat_stall_5",    32'(stat_stall),    32'd5);
`endif

        // Long operand wait, then illegal types.
        branch(4'b0010, 16'h5555, 3, 1'b0);
        branch(4'b1100, 16'h7777, 0, 1'b1);
        branch(4'b0000, 16'h8888, 0, 1'b1);
        branch(4'b0001, 16'h00c0, 1, 1'b1);
        idle_cycle();
        check_stats();

        // Asynchronous reset in the middle of WAIT_OPND.
        @(negedge clk);
        expect_cycle("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        drive(1'b1, 4'b0010, 16'hbeef, 1'b0, 1'b0);
        @(negedge clk);
        expect_cycle("rst_wait", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);
        drive(1'b0, 4'b0000, '0, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        last_pc      = '0;
        exp_resolved = 0;
        exp_taken    = 0;
        exp_stall    = 0;
        expect_cycle("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        check_stats();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) idle_cycle();
        check_stats();

        // Randomized transactions.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) typ = 4'($urandom);
            else                           typ = 4'b1000 >> $urandom_range(0, 3);
            branch(typ, 16'($urandom), $urandom_range(0, 3), 1'($urandom));
        end
        idle_cycle();
        check_stats();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Sequencing controller for the branch comparator in the 16-bit MIPS pipeline. It accepts a decoded branch from the ID stage and holds it until the register and carry operands are final. It then drives the comparator's one-hot select lines and samples the taken result. On a taken branch it issues a PC redirect and a timed IF/ID flush; until resolution it stalls the front end.

Parameters:
PC_W, 16, width of branch target and redirect PC.
FLUSH_CYCLES, 1, cycles flush_po stays high after a taken branch; legal range 1..3.

Ports:
clk_pi  in  1  clock; all state updates on rising edge.
reset_n_pi  in  1  asynchronous, active-low reset.
br_valid_pi  in  1  decode presents a branch this cycle.
br_type_pi  in  4  one-hot {eq, ge, le, carry}; 4'b1000 = eq … 4'b0001 = carry.
br_target_pi  in  PC_W  branch target address.
opnds_ready_pi  in  1  reg1/reg2 data and ALU carry are final (no pending writeback).
cmp_taken_pi  in  1  comparator's is-branch-taken result.
br_eq_po, br_ge_po, br_le_po, br_carry_po  out  1 each  comparator select lines.
br_ready_po  out  1  controller can accept a branch.
stall_po  out  1  freeze PC and IF/ID register.
flush_po  out  1  squash IF/ID contents.
redirect_valid_po  out  1  one-cycle pulse: load redirect_pc_po into PC.
redirect_pc_po  out  PC_W  taken-branch target.

Behaviour:
- States: IDLE, WAIT_OPND, RESOLVE, FLUSH. All outputs are Moore or registered; none depend combinationally on inputs.
- Reset (any time, including mid-branch): state=IDLE, flush counter=0, latched type/target=0.
  - br_ready_po=1; all other outputs 0; redirect_pc_po=0.
- IDLE:
  - br_ready_po=1; selects=0; stall_po=0.
  - br_valid_pi with a legal one-hot type latches type and target.
  - Next state is RESOLVE if opnds_ready_pi=1 that cycle, else WAIT_OPND.
  - Non-one-hot type (0000 or multi-hot) is ignored: stays IDLE, no stall, no redirect.
- WAIT_OPND:
  - stall_po=1; br_ready_po=0; latched select driven.
  - Advances to RESOLVE the cycle after opnds_ready_pi is sampled high. No timeout.
- RESOLVE:
  - stall_po=1; latched select driven.
  - cmp_taken_pi is sampled at the end of this cycle.
  - Taken: go to FLUSH, load counter=FLUSH_CYCLES.
  - Not taken: go to IDLE; no redirect, no flush.
- FLUSH:
  - flush_po=1; stall_po=0; selects=0; br_ready_po=0.
  - redirect_valid_po=1 and redirect_pc_po=target in the first FLUSH cycle only.
  - Counter decrements each cycle; returns to IDLE after FLUSH_CYCLES cycles.
  - br_valid_pi during FLUSH is ignored, since that instruction is squashed.
- Latency, operands ready at accept cycle T: RESOLVE at T+1; redirect pulse at T+2; next accept at T+2+FLUSH_CYCLES (taken) or T+2 (not taken).
- redirect_pc_po holds its last value outside the pulse. Consumers must qualify it with redirect_valid_po.
- Selects are always exactly one-hot or all-zero.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds three 16-bit outputs, all saturating at 16'hFFFF and cleared by reset:
  - stat_resolved_po: counts RESOLVE cycles.
  - stat_taken_po: counts taken branches.
  - stat_stall_po: counts cycles with stall_po=1.
- Undefined: these ports and all associated logic are absent; core behaviour is identical.

Decomposition:
- Package branch_ctrl_pkg holds:
  - state enum (IDLE, WAIT_OPND, RESOLVE, FLUSH);
  - one-hot type constants BR_EQ=4'b1000, BR_GE=4'b0100, BR_LE=4'b0010, BR_CARRY=4'b0001;
  - the is_onehot4 helper function.
- One sub-module, branch_ctrl_stats, holds the saturating counters. It is instantiated only under BRANCH_STATS_EN.

Test Plan:
- Taken beq, operands ready: br_valid=1, type=1000, target=16'h0040, cmp_taken=1 at RESOLVE -> stall high 1 cycle, redirect_valid pulse with pc 16'h0040 two cycles after accept, flush high FLUSH_CYCLES cycles, then br_ready=1.
- Not-taken bge: type=0100, cmp_taken=0 -> br_ge_po high during RESOLVE only; no redirect, no flush; br_ready back 2 cycles after accept.
- Operand wait: type=0010, opnds_ready low 3 cycles -> stall_po high 3 WAIT_OPND cycles plus 1 RESOLVE cycle; br_le_po held throughout.
- Illegal type 4'b1100 or 0000 with br_valid=1 -> stays IDLE; stall, flush, redirect and all selects remain 0.
- Reset mid-WAIT_OPND: deassert reset_n_pi asynchronously -> outputs return to reset values immediately, with no redirect pulse after release.
- With BRANCH_STATS_EN, FLUSH_CYCLES=2: 3 branches, 2 taken, 1 with 2-cycle operand wait -> stat_resolved=3, stat_taken=2, stat_stall=5.
